// File: rtl/proc_bus_ctrl.sv
// proc_bus_ctrl: control FSM for the extended processor datapath.
// Latches a 9-bit instruction (III XXX YYY) from DIN on the fetch edge.
// It then sequences the instruction over 1-3 cycles.
// Ports:
//   Clock   in        rising-edge system clock
//   Reset   in        asynchronous active-high reset
//   Run     in        start request, sampled only in T0
//   DIN     in  IW    instruction / immediate data
//   IRin    out       IR load strobe (Run in T0)
//   Rin     out NREG  one-hot register load enable
//   Rout    out NREG  one-hot register-to-bus select
//   Gout    out       G-to-bus select
//   DINout  out       DIN-to-bus select
//   Ain     out       A register load
//   Gin     out       G register load
//   AluOp   out 2     00 add, 01 sub, 10 and, 11 or
//   Done    out       one-cycle instruction-complete pulse
// Optional: define PROC_BUS_CTRL_LOGIC_OPS_EN to add opcodes
//   100 (and) and 101 (or). Without it, every 1xx opcode is a NOP.
module proc_bus_ctrl #(
   parameter int NREG = 8,
   parameter int IW   = 9
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            Run,
   input  logic [IW-1:0]   DIN,
   output logic            IRin,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            Gout,
   output logic            DINout,
   output logic            Ain,
   output logic            Gin,
   output logic [1:0]      AluOp,
   output logic            Done
);

   localparam int RW = $clog2(NREG);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   state_t          state;
   state_t          nstate;
   logic [IW-1:0]   ir;
   logic [2:0]      op;
   logic [RW-1:0]   rx;
   logic [RW-1:0]   ry;
   logic [NREG-1:0] selx;
   logic [NREG-1:0] sely;
   logic            is_alu;
   logic [1:0]      alu_code;

   assign op   = ir[IW-1 -: 3];
   assign rx   = ir[2*RW-1 -: RW];
   assign ry   = ir[RW-1:0];
   assign selx = NREG'(1) << rx;
   assign sely = NREG'(1) << ry;

   // Two-operand ALU opcodes share the T1-T3 sequence.
   always_comb begin
      is_alu   = 1'b0;
      alu_code = 2'b00;
      case (op)
         3'b010: begin
            is_alu   = 1'b1;
            alu_code = 2'b00;
         end
         3'b011: begin
            is_alu   = 1'b1;
            alu_code = 2'b01;
         end
`ifdef PROC_BUS_CTRL_LOGIC_OPS_EN
         3'b100: begin
            is_alu   = 1'b1;
            alu_code = 2'b10;
         end
         3'b101: begin
            is_alu   = 1'b1;
            alu_code = 2'b11;
         end
`endif
         default: begin
            is_alu   = 1'b0;
            alu_code = 2'b00;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= T0;
      end else begin
         state <= nstate;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ir <= '0;
      end else if (state == T0 && Run) begin
         ir <= DIN;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         T0: nstate = Run ? T1 : T0;
         T1: nstate = is_alu ? T2 : T0;
         T2: nstate = T3;
         T3: nstate = T0;
      endcase
   end

   always_comb begin
      IRin   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      Gout   = 1'b0;
      DINout = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AluOp  = 2'b00;
      Done   = 1'b0;
      unique case (state)
         T0: begin
            // Reset holds state at T0, so gating here keeps
            // IRin low while Reset is asserted.
            IRin = Run & ~Reset;
         end
         T1: begin
            if (is_alu) begin
               Rout = selx;
               Ain  = 1'b1;
            end else if (op == 3'b000) begin
               Rout = sely;
               Rin  = selx;
               Done = 1'b1;
            end else if (op == 3'b001) begin
               DINout = 1'b1;
               Rin    = selx;
               Done   = 1'b1;
            end else begin
               Done = 1'b1;
            end
         end
         T2: begin
            Rout  = sely;
            Gin   = 1'b1;
            AluOp = alu_code;
         end
         T3: begin
            Gout = 1'b1;
            Rin  = selx;
            Done = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_proc_bus_ctrl.sv
// tb_proc_bus_ctrl: scoreboard bench for proc_bus_ctrl.
// Expected per-cycle output vectors are queued at issue and popped per cycle.
module tb_proc_bus_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Run;
   logic [8:0] DIN;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       Gout;
   logic       DINout;
   logic       Ain;
   logic       Gin;
   logic [1:0] AluOp;
   logic       Done;

   int checks = 0;
   int errors = 0;

   logic [23:0] q[$];
   logic [23:0] outv;
   logic [23:0] expv;

   proc_bus_ctrl dut (
      .Clock (Clock),
      .Reset (Reset),
      .Run   (Run),
      .DIN   (DIN),
      .IRin  (IRin),
      .Rin   (Rin),
      .Rout  (Rout),
      .Gout  (Gout),
      .DINout(DINout),
      .Ain   (Ain),
      .Gin   (Gin),
      .AluOp (AluOp),
      .Done  (Done)
   );

   always #5 Clock = ~Clock;

   assign outv = {IRin, Rin, Rout, Gout, DINout, Ain, Gin, AluOp, Done};

   function automatic logic [23:0] mk(
      input logic       irin,
      input logic [7:0] rin,
      input logic [7:0] rout,
      input logic       gout,
      input logic       dinout,
      input logic       ain,
      input logic       gin,
      input logic [1:0] aluop,
      input logic       done
   );
      return {irin, rin, rout, gout, dinout, ain, gin, aluop, done};
   endfunction

   function automatic logic [7:0] bit8(input logic [2:0] n);
      logic [7:0] v;
      v    = 8'd0;
      v[n] = 1'b1;
      return v;
   endfunction

   // Reference model: expected vectors for the cycles after the fetch edge.
   task automatic push_instr(input logic [8:0] ins);
      logic [2:0] op;
      logic [2:0] x;
      logic [2:0] y;
      logic       alu;
      logic [1:0] code;
      op   = ins[8:6];
      x    = ins[5:3];
      y    = ins[2:0];
      alu  = 1'b0;
      code = 2'b00;
      if (op == 3'd2) begin alu = 1'b1; code = 2'b00; end
      if (op == 3'd3) begin alu = 1'b1; code = 2'b01; end
`ifdef PROC_BUS_CTRL_LOGIC_OPS_EN
      if (op == 3'd4) begin alu = 1'b1; code = 2'b10; end
      if (op == 3'd5) begin alu = 1'b1; code = 2'b11; end
`endif
      if (alu) begin
         q.push_back(mk(0, 8'h00, bit8(x), 0, 0, 1, 0, 2'b00, 0));
         q.push_back(mk(0, 8'h00, bit8(y), 0, 0, 0, 1, code, 0));
         q.push_back(mk(0, bit8(x), 8'h00, 1, 0, 0, 0, 2'b00, 1));
      end else if (op == 3'd0) begin
         q.push_back(mk(0, bit8(x), bit8(y), 0, 0, 0, 0, 2'b00, 1));
      end else if (op == 3'd1) begin
         q.push_back(mk(0, bit8(x), 8'h00, 0, 1, 0, 0, 2'b00, 1));
      end else begin
         q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1));
      end
   endtask

   // Bus exclusivity and one-hot enables, every cycle.
   always @(negedge Clock) begin
      if (Reset === 1'b0) begin
         checks++;
         if ($countones({Rout, Gout, DINout}) > 1 || $countones(Rin) > 1) begin
            errors++;
            $display("FAIL onehot: Rout=%b Gout=%b DINout=%b Rin=%b required at most one",
                     Rout, Gout, DINout, Rin);
         end
      end
   end

   task automatic test_reset();
      Reset = 1'b1;
      Run   = 1'b1;
      DIN   = 9'h1FF;
      #2;
      checks++;
      if (outv !== 24'h0) begin
         errors++;
         $display("FAIL reset_hold: got %h required %h", outv, 24'h0);
      end
      repeat (2) @(posedge Clock);
      #1;
      checks++;
      if (outv !== 24'h0) begin
         errors++;
         $display("FAIL reset_clocked: got %h required %h", outv, 24'h0);
      end
      Run = 1'b0;
      #1 Reset = 1'b0;
      repeat (2) begin
         @(posedge Clock);
         #1;
         checks++;
         if (outv !== 24'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", outv, 24'h0);
         end
      end
   endtask

   // Issue one instruction from an idle T0 and follow it back to T0.
   task automatic test_instr(input string name, input logic [8:0] ins);
      bit first;
      Run = 1'b1;
      DIN = ins;
      #1;
      expv = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
      checks++;
      if (outv !== expv) begin
         errors++;
         $display("FAIL %s_fetch: got %h required %h", name, outv, expv);
      end
      push_instr(ins);
      q.push_back(24'h0);
      first = 1'b1;
      while (q.size() > 0) begin
         @(posedge Clock);
         #1;
         if (first) begin
            Run   = 1'b0;
            DIN   = 9'h005;
            first = 1'b0;
         end
         expv = q.pop_front();
         checks++;
         if (outv !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, outv, expv);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k;
      Run = 1'b1;
      DIN = 9'b010_011_100;
      #1;
      expv = mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0);
      checks++;
      if (outv !== expv) begin
         errors++;
         $display("FAIL b2b_fetch: got %h required %h", outv, expv);
      end
      push_instr(9'b010_011_100);
      q.push_back(mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0));
      push_instr(9'b000_101_011);
      q.push_back(24'h0);
      k = 0;
      while (q.size() > 0) begin
         @(posedge Clock);
         #1;
         if (k == 0) DIN = 9'b000_101_011;
         if (k == 4) Run = 1'b0;
         expv = q.pop_front();
         checks++;
         if (outv !== expv) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %h required %h", k, outv, expv);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid();
      Run = 1'b1;
      DIN = 9'b010_010_010;
      push_instr(9'b010_010_010);
      @(posedge Clock);
      #1;
      Run  = 1'b0;
      expv = q.pop_front();
      checks++;
      if (outv !== expv) begin
         errors++;
         $display("FAIL rmid_t1: got %h required %h", outv, expv);
      end
      @(posedge Clock);
      #1;
      expv = q.pop_front();
      checks++;
      if (outv !== expv) begin
         errors++;
         $display("FAIL rmid_t2: got %h required %h", outv, expv);
      end
      q.delete();
      Run = 1'b1;
      #1 Reset = 1'b1;
      #1;
      checks++;
      if (outv !== 24'h0) begin
         errors++;
         $display("FAIL rmid_async: got %h required %h", outv, 24'h0);
      end
      Run = 1'b0;
      #1 Reset = 1'b0;
      repeat (4) begin
         @(posedge Clock);
         #1;
         checks++;
         if (outv !== 24'h0) begin
            errors++;
            $display("FAIL rmid_after: got %h required %h", outv, 24'h0);
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = 9'h0;
      test_reset();
      test_instr("mvi_r3", 9'b001_011_000);
      test_instr("mv_r1_r6", 9'b000_001_110);
      test_instr("sub_r2_r5", 9'b011_010_101);
      test_instr("add_r7_r0", 9'b010_111_000);
      test_instr("mv_r3_r3", 9'b000_011_011);
      test_instr("add_r2_r2", 9'b010_010_010);
      test_instr("op100", 9'b100_000_001);
      test_instr("op101", 9'b101_110_011);
      test_instr("op110", 9'b110_001_010);
      test_instr("op111", 9'b111_100_100);
      test_back_to_back();
      test_reset_mid();
      test_instr("mvi_after_reset", 9'b001_000_111);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_bus_ctrl.md
Name: proc_bus_ctrl

Overview:
- Control FSM for the extended processor datapath. It sits directly upstream of the bus multiplexer built from the mux2to1 / 74xx gate primitives.
- Latches a 9-bit instruction from DIN and drives the bus-source selects (Rout, Gout, DINout) that the mux tree consumes.
- Also drives the register/accumulator load enables and the ALU operation, sequencing each instruction over 1–3 cycles after fetch.

Parameters:
- NREG, 8, number of general registers; width of Rin/Rout; register fields are log2(NREG)=3 bits.
- IW, 9, instruction width; format III XXX YYY (opcode, Rx, Ry).

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears the FSM and IR immediately.
- Run  in  1  start request, sampled only in state T0.
- DIN  in  IW  instruction / immediate data input.
- IRin  out  1  IR load strobe; equals Run in T0.
- Rin  out  NREG  one-hot register load enable.
- Rout  out  NREG  one-hot register-to-bus select (to bus mux).
- Gout  out  1  G-to-bus select.
- DINout  out  1  DIN-to-bus select.
- Ain  out  1  A register load.
- Gin  out  1  G register load.
- AluOp  out  2  00 add, 01 sub, 10 and, 11 or.
- Done  out  1  instruction-complete pulse, 1 cycle.

Behaviour:
- State register: T0 (fetch), T1, T2, T3; 2-bit binary.
- IR: internal IW-bit register; loads DIN on the clock edge where state=T0 and Run=1.
- Outputs are combinational from state and IR, with IRin also depending on Run.
- All outputs are 0 while Reset=1 and out of reset in T0 with Run=0.
- Reset is asynchronous: state←T0, IR←0 with no clock required. Reset mid-instruction abandons the instruction; no Done pulse.
- T0: IRin=Run. If Run=1, go to T1; otherwise stay in T0. All other outputs are 0.
- T1, opcode 000 mv: Rout[Y]=1, Rin[X]=1, Done=1, go to T0.
- T1, opcode 001 mvi: DINout=1, Rin[X]=1, Done=1, go to T0.
- T1, opcodes 010 add and 011 sub: Rout[X]=1, Ain=1, go to T2.
- T2: Rout[Y]=1, Gin=1. AluOp=00 for add, 01 for sub. Go to T3.
- T3: Gout=1, Rin[X]=1, Done=1, go to T0.
- Unsupported opcodes (1xx without the optional feature): T1 asserts Done only, goes to T0, no register written.
- Bus exclusivity: in every cycle at most one of {Rout bits, Gout, DINout} is 1. Rin and Rout are always one-hot or zero.
- Latency in cycles, counting from the fetch edge to the Done cycle: mv/mvi = 1 (T1), ALU ops = 3 (T1–T3).
- Run is ignored outside T0. Deasserting it mid-instruction does not abort.
- Run held high re-fetches in the T0 immediately after Done, giving back-to-back instructions with one fetch cycle between.
- X=Y is legal: mv R3,R3 asserts Rout[3] and Rin[3] together; add R2,R2 doubles R2.
- AluOp is 00 in every state other than T2.

Optional Feature:
- Macro PROC_BUS_CTRL_LOGIC_OPS_EN.
- When defined: opcode 100 = and, 101 = or. They follow the add/sub T1–T3 sequence with AluOp=10 / 11 in T2.
- When undefined: 1xx opcodes are NOPs per the rule above, and AluOp never takes 10 or 11.
- Opcodes 110 and 111 are NOPs in both builds.

Test Plan:
- Reset during T2 of add → outputs drop to 0 asynchronously (before the next Clock edge); after release, stay in T0 with IR=0 and no Done.
- Run=1, DIN=001_011_000 (mvi R3) with DIN changed to 0x05 next cycle → cycle after fetch: DINout=1, Rin=00001000, Done=1; then T0.
- DIN=000_001_110 (mv R1,R6) → T1: Rout=01000000, Rin=00000010, Done=1; no other select high.
- DIN=011_010_101 (sub R2,R5) → T1: Rout[2]=1, Ain=1; T2: Rout[5]=1, Gin=1, AluOp=01; T3: Gout=1, Rin[2]=1, Done=1.
- Run held high across add then mv → Done pulses 3 cycles and then 1 cycle after the respective fetches; bus-select one-hot assertion never fires.
- DIN=100_000_001 → with the macro: T2 has AluOp=10, Done in T3. Without it: Done in T1, Rin=0.
